// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared Gray-code helpers for the independent-clock FIFO
//
// Purpose: binary/Gray conversion functions used by the FIFO pointer logic.
// The functions work on a fixed 32-bit container. Callers zero-extend their
// pointer into it and truncate the result back to the pointer width. That is
// exact, because bit i of the Gray code depends only on bits i and i+1 of
// the binary value.

package fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of the Gray bits at and above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - two-flop synchronizer for a Gray-coded pointer
//
// Purpose: brings a Gray-coded pointer from the other clock domain into
// clk_i. Only one bit changes per pointer step, so a bus-wide double-flop is
// safe. A sampled value is either the old pointer or the new pointer.
//
// Ports:
//   clk_i   destination-domain clock
//   rst_ni  destination-domain reset, asynchronous, active-low (clears to 0)
//   d_i     Gray pointer from the source domain
//   q_o     synchronized Gray pointer (two destination-clock stages later)

module gray_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/independent_clock_fifo.sv
// rtl/independent_clock_fifo.sv - dual-clock FIFO with Gray-pointer crossing
//
// Purpose: a DEPTH x DSIZE FIFO. Writes run on wr_clk and reads run on
// rd_clk. Each side keeps a binary pointer that is one bit wider than the
// address, which separates full from empty. Each side also keeps a
// registered Gray copy of that pointer. Only the Gray pointers cross
// domains, through gray_sync. The flags are registered from the next-state
// pointer, so each flag asserts on the edge that fills or drains the FIFO.
// Each flag deasserts only after the other side's pointer update has come
// through the synchronizer.
//
// Ports:
//   wr_clk, wr_rst_n  write clock and asynchronous active-low write reset
//   rd_clk, rd_rst_n  read clock and asynchronous active-low read reset
//   wdata, wr_en      write data and write request (wr_clk)
//   rdata, rd_en      registered read data and read request (rd_clk)
//   empty             no readable entry (rd_clk)
//   full              no free entry (wr_clk)

module independent_clock_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DSIZE = 8
) (
    input  logic             wr_clk,
    input  logic             wr_rst_n,
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             wr_en,
    output logic [DSIZE-1:0] rdata,
    input  logic             rd_en,
    output logic             empty,
    output logic             full
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    // The writer is a full lap ahead of the reader when their Gray pointers
    // differ exactly in the two MSBs.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    // ------------------------------------------------------------------
    // Storage: written in wr_clk, read in rd_clk, never reset
    // ------------------------------------------------------------------
    logic [DSIZE-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wbin_q;
    logic [PTR_W-1:0] wbin_d;
    logic [PTR_W-1:0] wgray_q;
    logic [PTR_W-1:0] wgray_d;
    logic [PTR_W-1:0] rgray_wq2;
    logic             full_q;
    logic             full_d;
    logic             wr_fire;

    assign wr_fire = wr_en & ~full_q;

    always_comb begin
        wbin_d  = wbin_q + PTR_W'(wr_fire);
        wgray_d = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_d)));
        full_d  = (wgray_d == (rgray_wq2 ^ FULL_MASK));
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_fire) begin
            mem_q[wbin_q[ADDR_W-1:0]] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read domain
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] rbin_q;
    logic [PTR_W-1:0] rbin_d;
    logic [PTR_W-1:0] rgray_q;
    logic [PTR_W-1:0] rgray_d;
    logic [PTR_W-1:0] wgray_rq2;
    logic             empty_q;
    logic             empty_d;
    logic [DSIZE-1:0] rdata_q;
    logic [DSIZE-1:0] rdata_d;
    logic             rd_fire;

    assign rd_fire = rd_en & ~empty_q;

    always_comb begin
        rbin_d  = rbin_q + PTR_W'(rd_fire);
        rgray_d = PTR_W'(bin2gray(GRAY_MAX_W'(rbin_d)));
        empty_d = (rgray_d == wgray_rq2);
        // Hold the last value when no read is accepted.
        rdata_d = rd_fire ? mem_q[rbin_q[ADDR_W-1:0]] : rdata_q;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            empty_q <= 1'b1;
            rdata_q <= '0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            empty_q <= empty_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Pointer crossings: one synchronizer per direction
    // ------------------------------------------------------------------
    gray_sync #(
        .WIDTH (PTR_W)
    ) u_sync_w2r (
        .clk_i  (rd_clk),
        .rst_ni (rd_rst_n),
        .d_i    (wgray_q),
        .q_o    (wgray_rq2)
    );

    gray_sync #(
        .WIDTH (PTR_W)
    ) u_sync_r2w (
        .clk_i  (wr_clk),
        .rst_ni (wr_rst_n),
        .d_i    (rgray_q),
        .q_o    (rgray_wq2)
    );

    assign rdata = rdata_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: tb/tb_independent_clock_fifo.sv
// tb/tb_independent_clock_fifo.sv - self-checking bench for independent_clock_fifo

module tb_independent_clock_fifo;

    localparam int DEPTH = 4;
    localparam int DSIZE = 8;

    logic             wr_clk = 1'b0;
    logic             rd_clk = 1'b0;
    logic             wr_rst_n;
    logic             rd_rst_n;
    logic [DSIZE-1:0] wdata;
    logic             wr_en;
    logic [DSIZE-1:0] rdata;
    logic             rd_en;
    logic             empty;
    logic             full;

    independent_clock_fifo #(
        .DEPTH (DEPTH),
        .DSIZE (DSIZE)
    ) dut (
        .wr_clk   (wr_clk),
        .wr_rst_n (wr_rst_n),
        .rd_clk   (rd_clk),
        .rd_rst_n (rd_rst_n),
        .wdata    (wdata),
        .wr_en    (wr_en),
        .rdata    (rdata),
        .rd_en    (rd_en),
        .empty    (empty),
        .full     (full)
    );

    // 150 MHz : 100 MHz period ratio (20 : 30). The read clock is offset,
    // so the rising edges of the two clocks never coincide.
    initial forever #10 wr_clk = ~wr_clk;
    initial begin
        #3;
        forever #15 rd_clk = ~rd_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [DSIZE-1:0] model_q[$];
    logic [DSIZE-1:0] held;
    event             first_rd;
    int               lat;

    typedef struct {
        logic             en;
        logic [DSIZE-1:0] exp_val;
        logic             exp_flag;
    } vec_t;

    vec_t wr_tab[6];
    vec_t rd_tab[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One write-domain cycle against the queue model.
    task automatic wr_step(input logic en, input logic [DSIZE-1:0] d);
        logic full_pre;
        full_pre = full;
        wr_en    = en;
        wdata    = d;
        @(posedge wr_clk);
        #1;
        if (en && !full_pre) begin
            model_q.push_back(d);
            check("no_overflow", 32'(model_q.size() <= DEPTH), 1);
        end
        if (!full) check("not_full_has_room", 32'(model_q.size() < DEPTH), 1);
    endtask

    // One read-domain cycle against the queue model.
    task automatic rd_step(input logic en);
        logic empty_pre;
        empty_pre = empty;
        rd_en     = en;
        @(posedge rd_clk);
        #1;
        if (en && !empty_pre) begin
            check("no_underflow", 32'(model_q.size() > 0), 1);
            if (model_q.size() > 0) held = model_q.pop_front();
        end
        check("rdata_stream", 32'(rdata), 32'(held));
        if (!empty) check("not_empty_has_data", 32'(model_q.size() > 0), 1);
    endtask

    task automatic wait_not_empty(input string name);
        int n;
        n = 0;
        while (empty && n < 10) begin
            @(posedge rd_clk);
            #1;
            n++;
        end
        check(name, 32'(empty), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [DSIZE-1:0] wcnt;
        logic             full_pre;

        wr_tab[0] = '{1'b1, 8'd1, 1'b0};
        wr_tab[1] = '{1'b1, 8'd2, 1'b0};
        wr_tab[2] = '{1'b1, 8'd3, 1'b0};
        wr_tab[3] = '{1'b1, 8'd4, 1'b1};
        wr_tab[4] = '{1'b1, 8'd4, 1'b1};
        wr_tab[5] = '{1'b1, 8'd4, 1'b1};

        rd_tab[0] = '{1'b1, 8'd0, 1'b0};
        rd_tab[1] = '{1'b1, 8'd1, 1'b0};
        rd_tab[2] = '{1'b1, 8'd2, 1'b0};
        rd_tab[3] = '{1'b1, 8'd3, 1'b1};
        rd_tab[4] = '{1'b1, 8'd3, 1'b1};
        rd_tab[5] = '{1'b1, 8'd3, 1'b1};

        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wdata    = '0;
        wr_rst_n = 1'b0;
        rd_rst_n = 1'b0;
        #40;
        wr_rst_n = 1'b1;
        rd_rst_n = 1'b1;
        repeat (2) @(posedge rd_clk);
        #1;
        check("reset_empty", 32'(empty), 1);
        check("reset_full", 32'(full), 0);
        check("reset_rdata", 32'(rdata), 0);

        // Fill past capacity. The producer advances wdata only when a write is accepted.
        wcnt = '0;
        for (int i = 0; i < 6; i++) begin
            full_pre = full;
            wr_en    = wr_tab[i].en;
            wdata    = wcnt;
            @(posedge wr_clk);
            #1;
            if (wr_en && !full_pre) wcnt++;
            check("fill_full", 32'(full), 32'(wr_tab[i].exp_flag));
            check("fill_wdata_next", 32'(wcnt), 32'(wr_tab[i].exp_val));
        end
        wr_en = 1'b0;

        // Drain past empty, and time the full release in the write domain.
        wait_not_empty("fill_visible");
        check("full_before_drain", 32'(full), 1);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    rd_en = rd_tab[i].en;
                    @(posedge rd_clk);
                    if (i == 0) -> first_rd;
                    #1;
                    check("drain_rdata", 32'(rdata), 32'(rd_tab[i].exp_val));
                    check("drain_empty", 32'(empty), 32'(rd_tab[i].exp_flag));
                end
                rd_en = 1'b0;
            end
            begin
                @(first_rd);
                lat = 0;
                do begin
                    @(posedge wr_clk);
                    #1;
                    lat++;
                end while (full && lat < 6);
                check("full_release_2to3", 32'(lat >= 2 && lat <= 3), 1);
            end
        join

        // A single write into the empty FIFO, with the empty release latency timed.
        repeat (3) @(posedge rd_clk);
        #1;
        check("idle_empty", 32'(empty), 1);
        wdata = 8'hA5;
        wr_en = 1'b1;
        @(posedge wr_clk);
        #1;
        wr_en = 1'b0;
        check("single_not_full", 32'(full), 0);
        lat = 0;
        while (empty && lat < 8) begin
            @(posedge rd_clk);
            #1;
            lat++;
        end
        check("empty_release_2to3", 32'(lat >= 2 && lat <= 3), 1);
        rd_en = 1'b1;
        @(posedge rd_clk);
        #1;
        rd_en = 1'b0;
        check("single_rdata", 32'(rdata), 32'hA5);
        check("single_empty_again", 32'(empty), 1);

        // Pulse both resets mid-stream while two entries are still outstanding.
        for (int i = 0; i < 3; i++) begin
            wdata = 8'h10 + 8'(i);
            wr_en = 1'b1;
            @(posedge wr_clk);
            #1;
        end
        wr_en = 1'b0;
        wait_not_empty("pre_reset_visible");
        rd_en = 1'b1;
        @(posedge rd_clk);
        #1;
        rd_en = 1'b0;
        check("pre_reset_rdata", 32'(rdata), 32'h10);
        @(negedge wr_clk);
        wr_rst_n = 1'b0;
        rd_rst_n = 1'b0;
        #25;
        check("in_reset_full", 32'(full), 0);
        check("in_reset_empty", 32'(empty), 1);
        check("in_reset_rdata", 32'(rdata), 0);
        #20;
        wr_rst_n = 1'b1;
        rd_rst_n = 1'b1;
        repeat (2) @(posedge wr_clk);
        #1;
        check("post_reset_full", 32'(full), 0);
        check("post_reset_empty", 32'(empty), 1);
        check("post_reset_rdata", 32'(rdata), 0);
        wdata = 8'h3C;
        wr_en = 1'b1;
        @(posedge wr_clk);
        #1;
        wr_en = 1'b0;
        wait_not_empty("post_reset_visible");
        rd_en = 1'b1;
        @(posedge rd_clk);
        #1;
        rd_en = 1'b0;
        check("post_reset_first_read", 32'(rdata), 32'h3C);
        check("post_reset_empty_after", 32'(empty), 1);

        // Random traffic on both sides against the queue model.
        held = 8'h3C;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    wr_step(1'($urandom_range(0, 1)), DSIZE'($urandom));
                end
                wr_en = 1'b0;
            end
            begin
                for (int i = 0; i < 225; i++) begin
                    rd_step(1'($urandom_range(0, 1)));
                end
                rd_en = 1'b0;
            end
        join
        for (int i = 0; i < 40 && model_q.size() > 0; i++) begin
            rd_step(1'b1);
        end
        rd_step(1'b0);
        check("random_drained", 32'(model_q.size()), 0);
        check("random_final_empty", 32'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/independent_clock_fifo.md
INDEPENDENT_CLOCK_FIFO -- requirements
Module: independent_clock_fifo

Interface
REQ-001 The parameter DEPTH SHALL default to 4 and set the number of entries; it SHALL be a power of two and at least 2.
REQ-002 The parameter DSIZE SHALL default to 8 and set the data width in bits.
REQ-003 Port wr_clk SHALL be an input, 1 bit: the write-domain clock.
REQ-004 Port wr_rst_n SHALL be an input, 1 bit: the write-domain reset, asynchronous, active-low.
REQ-005 Port rd_clk SHALL be an input, 1 bit: the read-domain clock, asynchronous to wr_clk.
REQ-006 Port rd_rst_n SHALL be an input, 1 bit: the read-domain reset, asynchronous, active-low.
REQ-007 Port wdata SHALL be an input, DSIZE bits: write data, sampled on wr_clk.
REQ-008 Port wr_en SHALL be an input, 1 bit: write request in the wr_clk domain.
REQ-009 Port rdata SHALL be an output, DSIZE bits: registered read data in the rd_clk domain.
REQ-010 Port rd_en SHALL be an input, 1 bit: read request in the rd_clk domain.
REQ-011 Port empty SHALL be an output, 1 bit: FIFO has no readable entry (rd_clk domain).
REQ-012 Port full SHALL be an output, 1 bit: FIFO has no free entry (wr_clk domain).

Function
REQ-013 A write SHALL occur on a wr_clk rising edge when wr_en=1 and full=0, storing wdata at the write pointer and incrementing it.
REQ-014 A write attempt while full=1 SHALL be dropped; memory and pointers SHALL be unchanged.
REQ-015 A read SHALL occur on an rd_clk rising edge when rd_en=1 and empty=0; rdata SHALL present the oldest entry one cycle later (registered, not first-word-fall-through), and the read pointer SHALL increment.
REQ-016 A read attempt while empty=1 SHALL be ignored; rdata SHALL hold its last value.
REQ-017 The read and write pointers SHALL each be log2(DEPTH)+1 bits wide, binary-incremented and wrapping modulo 2*DEPTH, with memory addressed by the low log2(DEPTH) bits.
REQ-018 Each pointer SHALL cross domains as Gray code through a two-flop synchronizer; no other signal SHALL cross domains.
REQ-019 The full flag SHALL be registered in wr_clk and asserted when the next write Gray pointer equals the synchronized read Gray pointer with its two MSBs inverted.
REQ-020 The empty flag SHALL be registered in rd_clk and asserted when the next read Gray pointer equals the synchronized write Gray pointer.
REQ-021 full SHALL assert on the same edge that accepts the DEPTH-th outstanding write; empty SHALL assert on the same edge that accepts the last outstanding read.
REQ-022 Flag deassertion SHALL be pessimistic: empty SHALL fall 2-3 rd_clk cycles after a write, and full SHALL fall 2-3 wr_clk cycles after a read.
REQ-023 Exactly DEPTH entries SHALL be usable, and ordering SHALL be strictly FIFO across pointer wrap-around.
REQ-024 Simultaneous read and write at any fill level, including full and empty, SHALL each follow their own domain rules without data loss or duplication.

Reset
REQ-025 wr_rst_n low SHALL asynchronously clear the write pointer (binary and Gray), the write-side synchronizer flops, and full (full=0).
REQ-026 rd_rst_n low SHALL asynchronously clear the read pointer (binary and Gray), the read-side synchronizer flops, and rdata ('0), and SHALL set empty=1.
REQ-027 The memory array SHALL NOT be reset.
REQ-028 Correct operation after reset SHALL require both resets to have been asserted together; asserting only one mid-operation SHALL NOT be required to preserve data.

Structure
REQ-029 The bin2gray and gray2bin functions SHALL reside in the shared package fifo_pkg; ADDR_W = $clog2(DEPTH) SHALL be a local parameter.
REQ-030 The two-flop synchronizer SHALL be one sub-module, gray_sync (parameterized width, with clock and async active-low reset), instantiated once per direction.
REQ-031 The memory SHALL be a DEPTH x DSIZE register array written in wr_clk and read in rd_clk.

Verification
REQ-032 Scenario: after both resets, with wr_clk at 150 MHz and rd_clk at 100 MHz, check empty=1, full=0, rdata=0.
REQ-033 Scenario: hold wr_en for 6 wr_clk cycles with wdata counting 0,1,2,... -> exactly 0..3 are stored, full=1 after the 4th write, and wdata stops advancing at 4.
REQ-034 Scenario: then hold rd_en for 6 rd_clk cycles -> rdata sequence is 0,1,2,3, empty=1 after the 4th read, and rdata holds 3; full drops within 3 wr_clk cycles of the first read.
REQ-035 Scenario: a single write into an empty FIFO -> empty deasserts 2-3 rd_clk cycles later, and the read returns the written value.
REQ-036 Scenario: random wr_en and rd_en (50% duty each) for 100+ cycles -> the read stream equals the accepted write stream in order, with no overflow or underflow.
REQ-037 Scenario: pulse both resets mid-stream -> full=0, empty=1, rdata=0, and the next written value is the next value read.
